// File: rtl/claw_axis_sequencer.sv
// -----------------------------------------------------------------------------
// claw_axis_sequencer
//
// Purpose:
//   Motion controller for the two claw-game stepper axes. After reset it homes
//   both axes against their home switches. Once both are home it turns the
//   debounced button presses into per-axis driver enable and direction. It also
//   tracks each axis position in steps and keeps every axis between the home
//   switch (position 0) and the far soft limit MAX_POS.
//
// Parameters:
//   POS_W         width of each position counter
//   MAX_POS       far soft limit in steps
//   HOME_TIMEOUT  step_tick count allowed for homing before entering FAULT
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   step_tick  in   one-clk pulse per motor step
//   btn[3:0]   in   [0] ax0 dir, [1] ax0 move, [2] ax1 dir, [3] ax1 move
//   limit[1:0] in   home switches, active high, [n] = axis n at position 0
//   home_req   in   one-clk pulse, request re-home
//   axN_en     out  axis N driver enable
//   axN_dir    out  axis N direction, 1 = away from home, 0 = toward home
//   axN_pos    out  axis N position in steps
//   state[1:0] out  00 HOME, 01 READY, 11 FAULT
//   fault      out  high while in FAULT
//
// Build option:
//   CLAW_HOLD_MODE_EN  undefined: a move-button press toggles the axis run
//                      latch (toggle-lock).
//                      defined: hold-to-run. The run latch follows the move
//                      button level. An axis that got blocked stays stopped
//                      until its button is released and pressed again.
// -----------------------------------------------------------------------------
module claw_axis_sequencer #(
    parameter int POS_W        = 12,
    parameter int MAX_POS      = 1000,
    parameter int HOME_TIMEOUT = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic [3:0]       btn,
    input  logic [1:0]       limit,
    input  logic             home_req,
    output logic             ax0_en,
    output logic             ax0_dir,
    output logic             ax1_en,
    output logic             ax1_dir,
    output logic [POS_W-1:0] ax0_pos,
    output logic [POS_W-1:0] ax1_pos,
    output logic [1:0]       state,
    output logic             fault
);

    localparam int TICK_W = $clog2(HOME_TIMEOUT + 1);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(MAX_POS);
    // Timeout is detected on the tick that would take the counter to HOME_TIMEOUT.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HOME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HOME  = 2'b00,
        ST_READY = 2'b01,
        ST_FAULT = 2'b11
    } state_t;

    state_t            state_reg;
    logic [1:0]        en_reg;
    logic [1:0]        dir_reg;
    logic [1:0]        run_reg;
    logic [POS_W-1:0]  pos_reg [2];
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              fault_reg;
`ifdef CLAW_HOLD_MODE_EN
    logic [1:0]        lock_reg;
    logic [1:0]        lock_next;
`else
    logic [1:0]        move_prev_reg;
`endif

    logic [1:0]        btn_dir;
    logic [1:0]        btn_move;
    logic [1:0]        dir_next;
    logic [1:0]        run_next;
    logic [1:0]        blocked;
    logic [POS_W-1:0]  pos_inc  [2];
    logic [POS_W-1:0]  pos_dec  [2];
    logic [POS_W-1:0]  pos_step [2];
    logic [POS_W-1:0]  pos_next [2];

    // Per-axis next-state logic used while READY.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            assign btn_dir[gi]  = btn[2*gi];
            assign btn_move[gi] = btn[2*gi+1];

            // Direction may only change on a step boundary or while the axis is idle.
            assign dir_next[gi] = (step_tick || !en_reg[gi]) ? btn_dir[gi] : dir_reg[gi];

            // Steps use the registered enable/direction that the driver actually saw.
            assign pos_inc[gi]  = (pos_reg[gi] >= POS_MAX) ? POS_MAX : pos_reg[gi] + 1'b1;
            assign pos_dec[gi]  = (pos_reg[gi] == '0) ? '0 : pos_reg[gi] - 1'b1;
            assign pos_step[gi] = (step_tick && en_reg[gi])
                                  ? (dir_reg[gi] ? pos_inc[gi] : pos_dec[gi])
                                  : pos_reg[gi];

            // The home switch re-zeroes the axis only when travelling toward it;
            // moving away the switch is still closed for a few steps.
            assign pos_next[gi] = (limit[gi] && !dir_next[gi]) ? '0 : pos_step[gi];

            assign blocked[gi] = dir_next[gi] ? (pos_next[gi] >= POS_MAX)
                                              : (limit[gi] || (pos_next[gi] == '0));

`ifdef CLAW_HOLD_MODE_EN
            assign run_next[gi]  = btn_move[gi] && !lock_reg[gi] && !blocked[gi];
            assign lock_next[gi] = btn_move[gi] && (lock_reg[gi] || blocked[gi]);
`else
            // Blocking overrides a press that arrives in the same clk.
            assign run_next[gi] = !blocked[gi] &&
                                  (run_reg[gi] ^ (btn_move[gi] && !move_prev_reg[gi]));
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_HOME;
            en_reg       <= 2'b00;
            dir_reg      <= 2'b00;
            run_reg      <= 2'b00;
            pos_reg[0]   <= '0;
            pos_reg[1]   <= '0;
            tick_cnt_reg <= '0;
            fault_reg    <= 1'b0;
`ifdef CLAW_HOLD_MODE_EN
            lock_reg     <= 2'b00;
`else
            move_prev_reg <= 2'b00;
`endif
        end else begin
            // The edge reference tracks the buttons in every state, so a button
            // held through homing does not count as a fresh press.
`ifdef CLAW_HOLD_MODE_EN
            lock_reg <= (state_reg == ST_READY && !home_req) ? lock_next : 2'b00;
`else
            move_prev_reg <= btn_move;
`endif
            case (state_reg)
                ST_HOME: begin
                    run_reg <= 2'b00;
                    for (int i = 0; i < 2; i++) begin
                        en_reg[i] <= !limit[i];
                        if (limit[i]) begin
                            pos_reg[i] <= '0;
                        end else begin
                            dir_reg[i] <= 1'b0;
                        end
                    end
                    if (&limit) begin
                        state_reg    <= ST_READY;
                        tick_cnt_reg <= '0;
                    end else if (home_req) begin
                        tick_cnt_reg <= '0;
                    end else if (step_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        if (tick_cnt_reg >= TICK_LAST) begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                            en_reg    <= 2'b00;
                        end
                    end
                end

                ST_READY: begin
                    if (home_req) begin
                        // One idle clk with drivers off before homing drive starts.
                        state_reg    <= ST_HOME;
                        run_reg      <= 2'b00;
                        en_reg       <= 2'b00;
                        tick_cnt_reg <= '0;
                    end else begin
                        dir_reg <= dir_next;
                        run_reg <= run_next;
                        en_reg  <= run_next;
                        for (int i = 0; i < 2; i++) begin
                            pos_reg[i] <= pos_next[i];
                        end
                    end
                end

                ST_FAULT: begin
                    en_reg  <= 2'b00;
                    run_reg <= 2'b00;
                    if (home_req) begin
                        state_reg    <= ST_HOME;
                        fault_reg    <= 1'b0;
                        tick_cnt_reg <= '0;
                    end
                end

                default: begin
                    state_reg <= ST_HOME;
                    en_reg    <= 2'b00;
                    run_reg   <= 2'b00;
                end
            endcase
        end
    end

    assign ax0_en  = en_reg[0];
    assign ax1_en  = en_reg[1];
    assign ax0_dir = dir_reg[0];
    assign ax1_dir = dir_reg[1];
    assign ax0_pos = pos_reg[0];
    assign ax1_pos = pos_reg[1];
    assign state   = state_reg;
    assign fault   = fault_reg;

endmodule

// File: tb/tb_claw_axis_sequencer.sv
// -----------------------------------------------------------------------------
// tb_claw_axis_sequencer
//
// Directed bench for claw_axis_sequencer. Two instances share all inputs:
// "dut" with default parameters and "dut8" with MAX_POS = 8 for the far
// soft-limit case. A table of vectors (inputs, repeat count, expected outputs)
// covers homing, toggle-lock moves, direction changes, the home-switch zeroing
// and re-homing. Hand-written sequences cover the homing timeout, FAULT exit
// and an asynchronous reset while an axis is moving.
// -----------------------------------------------------------------------------
module tb_claw_axis_sequencer;

    localparam int POS_W = 12;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             step_tick = 1'b0;
    logic             home_req  = 1'b0;
    logic [3:0]       btn       = 4'b0000;
    logic [1:0]       limit     = 2'b00;

    logic             ax0_en, ax0_dir, ax1_en, ax1_dir, fault;
    logic [POS_W-1:0] ax0_pos, ax1_pos;
    logic [1:0]       state;

    logic             s_ax0_en, s_ax0_dir, s_ax1_en, s_ax1_dir, s_fault;
    logic [POS_W-1:0] s_ax0_pos, s_ax1_pos;
    logic [1:0]       s_state;

    int n_cmp = 0;
    int n_bad = 0;

    claw_axis_sequencer dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .btn(btn), .limit(limit),
        .home_req(home_req), .ax0_en(ax0_en), .ax0_dir(ax0_dir), .ax1_en(ax1_en),
        .ax1_dir(ax1_dir), .ax0_pos(ax0_pos), .ax1_pos(ax1_pos), .state(state),
        .fault(fault)
    );

    claw_axis_sequencer #(.MAX_POS(8)) dut8 (
        .clk(clk), .rst(rst), .step_tick(step_tick), .btn(btn), .limit(limit),
        .home_req(home_req), .ax0_en(s_ax0_en), .ax0_dir(s_ax0_dir), .ax1_en(s_ax1_en),
        .ax1_dir(s_ax1_dir), .ax0_pos(s_ax0_pos), .ax1_pos(s_ax1_pos), .state(s_state),
        .fault(s_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
    task automatic drive(input logic [3:0] b, input logic [1:0] l,
                         input logic h, input logic t);
        btn       = b;
        limit     = l;
        home_req  = h;
        step_tick = t;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic [1:0] lim;
        logic       hr;
        logic       tk;
        int         reps;
        logic [1:0] st;
        logic [1:0] en;    // {ax1, ax0}
        logic [1:0] dir;   // {ax1, ax0}
        int         p0;
        int         p1;
        logic       c8;    // check dut8 axis 0 on this vector
        int         p8;
        logic       e8;
    } vec_t;

    vec_t vecs [26];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        //            btn      lim    hr    tk  reps  st     en     dir   p0  p1  c8   p8  e8
        vecs[0]  = '{4'b0000, 2'b00, 1'b0, 1'b1, 5, 2'b00, 2'b11, 2'b00,  0, 0, 1'b1, 0, 1'b1};
        vecs[1]  = '{4'b0000, 2'b11, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  0, 0, 1'b1, 0, 1'b0};
        vecs[2]  = '{4'b0000, 2'b11, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  0, 0, 1'b0, 0, 1'b0};
        vecs[3]  = '{4'b0001, 2'b11, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b01,  0, 0, 1'b0, 0, 1'b0};
        vecs[4]  = '{4'b0011, 2'b11, 1'b0, 1'b0, 1, 2'b01, 2'b01, 2'b01,  0, 0, 1'b1, 0, 1'b1};
        vecs[5]  = '{4'b0001, 2'b00, 1'b0, 1'b1,10, 2'b01, 2'b01, 2'b01, 10, 0, 1'b1, 8, 1'b0};
        vecs[6]  = '{4'b0011, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b01, 10, 0, 1'b1, 8, 1'b0};
        vecs[7]  = '{4'b0001, 2'b00, 1'b0, 1'b1, 3, 2'b01, 2'b00, 2'b01, 10, 0, 1'b1, 8, 1'b0};
        vecs[8]  = '{4'b0011, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b01, 2'b01, 10, 0, 1'b1, 8, 1'b0};
        vecs[9]  = '{4'b0010, 2'b00, 1'b0, 1'b0, 2, 2'b01, 2'b01, 2'b01, 10, 0, 1'b0, 0, 1'b0};
        vecs[10] = '{4'b0000, 2'b00, 1'b0, 1'b1, 1, 2'b01, 2'b01, 2'b00, 11, 0, 1'b0, 0, 1'b0};
        vecs[11] = '{4'b0000, 2'b00, 1'b0, 1'b1, 3, 2'b01, 2'b01, 2'b00,  8, 0, 1'b0, 0, 1'b0};
        vecs[12] = '{4'b0010, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  8, 0, 1'b0, 0, 1'b0};
        vecs[13] = '{4'b0100, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b10,  8, 0, 1'b0, 0, 1'b0};
        vecs[14] = '{4'b1100, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b10, 2'b10,  8, 0, 1'b0, 0, 1'b0};
        vecs[15] = '{4'b0100, 2'b00, 1'b0, 1'b1, 5, 2'b01, 2'b10, 2'b10,  8, 5, 1'b0, 0, 1'b0};
        vecs[16] = '{4'b1100, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b10,  8, 5, 1'b0, 0, 1'b0};
        vecs[17] = '{4'b0000, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  8, 5, 1'b0, 0, 1'b0};
        vecs[18] = '{4'b1000, 2'b00, 1'b0, 1'b0, 1, 2'b01, 2'b10, 2'b00,  8, 5, 1'b0, 0, 1'b0};
        vecs[19] = '{4'b0000, 2'b00, 1'b0, 1'b1, 2, 2'b01, 2'b10, 2'b00,  8, 3, 1'b0, 0, 1'b0};
        vecs[20] = '{4'b0000, 2'b10, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  8, 0, 1'b0, 0, 1'b0};
        vecs[21] = '{4'b1000, 2'b10, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b00,  8, 0, 1'b0, 0, 1'b0};
        vecs[22] = '{4'b0100, 2'b10, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b10,  8, 0, 1'b0, 0, 1'b0};
        vecs[23] = '{4'b0100, 2'b10, 1'b1, 1'b0, 1, 2'b00, 2'b00, 2'b10,  8, 0, 1'b0, 0, 1'b0};
        vecs[24] = '{4'b0000, 2'b10, 1'b0, 1'b0, 1, 2'b00, 2'b01, 2'b10,  8, 0, 1'b0, 0, 1'b0};
        vecs[25] = '{4'b0000, 2'b11, 1'b0, 1'b0, 1, 2'b01, 2'b00, 2'b10,  0, 0, 1'b0, 0, 1'b0};

        // Reset state, with clocks running under reset.
        #22;
        check("reset.state", 32'(state), 32'(2'b00));
        check("reset.en", 32'({ax1_en, ax0_en}), 32'(2'b00));
        check("reset.dir", 32'({ax1_dir, ax0_dir}), 32'(2'b00));
        check("reset.pos0", 32'(ax0_pos), 32'd0);
        check("reset.pos1", 32'(ax1_pos), 32'd0);
        check("reset.fault", 32'(fault), 32'd0);
        check("reset.dut8_en", 32'({s_ax1_en, s_ax0_en}), 32'(2'b00));

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 26; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].btn, vecs[i].lim, vecs[i].hr, vecs[i].tk);
            end
            check($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d.en", i), 32'({ax1_en, ax0_en}), 32'(vecs[i].en));
            check($sformatf("v%0d.dir", i), 32'({ax1_dir, ax0_dir}), 32'(vecs[i].dir));
            check($sformatf("v%0d.pos0", i), 32'(ax0_pos), 32'(vecs[i].p0));
            check($sformatf("v%0d.pos1", i), 32'(ax1_pos), 32'(vecs[i].p1));
            check($sformatf("v%0d.fault", i), 32'(fault), 32'd0);
            if (vecs[i].c8) begin
                check($sformatf("v%0d.max8_pos0", i), 32'(s_ax0_pos), 32'(vecs[i].p8));
                check($sformatf("v%0d.max8_en0", i), 32'(s_ax0_en), 32'(vecs[i].e8));
            end
        end

        // Homing timeout, with a home_req restart of the tick count part way.
        drive(4'b0000, 2'b11, 1'b1, 1'b0);
        check("rehome.state", 32'(state), 32'(2'b00));
        check("rehome.en", 32'({ax1_en, ax0_en}), 32'(2'b00));
        repeat (1000) drive(4'b0000, 2'b00, 1'b0, 1'b1);
        check("home1000.state", 32'(state), 32'(2'b00));
        check("home1000.en", 32'({ax1_en, ax0_en}), 32'(2'b11));
        drive(4'b0000, 2'b00, 1'b1, 1'b0);
        check("home_restart.state", 32'(state), 32'(2'b00));
        repeat (2046) drive(4'b0000, 2'b00, 1'b0, 1'b1);
        check("tick2046.state", 32'(state), 32'(2'b00));
        check("tick2046.fault", 32'(fault), 32'd0);
        drive(4'b0000, 2'b00, 1'b0, 1'b1);
        check("tick2047.state", 32'(state), 32'(2'b11));
        check("tick2047.fault", 32'(fault), 32'd1);
        check("tick2047.en", 32'({ax1_en, ax0_en}), 32'(2'b00));

        // Buttons are ignored in FAULT; only home_req leaves it.
        drive(4'b0011, 2'b00, 1'b0, 1'b1);
        check("fault_btn.state", 32'(state), 32'(2'b11));
        check("fault_btn.en", 32'({ax1_en, ax0_en}), 32'(2'b00));
        check("fault_btn.pos0", 32'(ax0_pos), 32'd0);
        drive(4'b0000, 2'b00, 1'b1, 1'b0);
        check("fault_exit.state", 32'(state), 32'(2'b00));
        check("fault_exit.fault", 32'(fault), 32'd0);
        check("fault_exit.en", 32'({ax1_en, ax0_en}), 32'(2'b00));
        drive(4'b0000, 2'b00, 1'b0, 1'b0);
        check("homing.en", 32'({ax1_en, ax0_en}), 32'(2'b11));

        // Asynchronous reset while axis 0 is moving.
        drive(4'b0000, 2'b11, 1'b0, 1'b0);
        check("ready2.state", 32'(state), 32'(2'b01));
        drive(4'b0001, 2'b11, 1'b0, 1'b0);
        drive(4'b0011, 2'b11, 1'b0, 1'b0);
        repeat (3) drive(4'b0001, 2'b00, 1'b0, 1'b1);
        check("moving.en0", 32'(ax0_en), 32'd1);
        check("moving.pos0", 32'(ax0_pos), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.en0", 32'(ax0_en), 32'd0);
        check("async_rst.pos0", 32'(ax0_pos), 32'd0);
        check("async_rst.state", 32'(state), 32'(2'b00));
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, 2'b00, 1'b0, 1'b0);
        check("post_rst.en", 32'({ax1_en, ax0_en}), 32'(2'b11));
        check("post_rst.state", 32'(state), 32'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
